fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameters: BITS, default 32, datapath/address width; DEPTH, default 4, instruction queue entries (power of 2, >=2); RESET_ADDR, default 0, first fetch address.
REQ-002 SHALL have ports: clk  in  1  system clock; rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have: imem_req  out  1  instruction memory read request this cycle.
REQ-004 SHALL have: imem_addr  out  BITS  word address for imem_req.
REQ-005 SHALL have: imem_rdata  in  BITS  read data, valid the cycle after the request.
REQ-006 SHALL have: redirect  in  1  branch/jump taken; flush and refetch.
REQ-007 SHALL have: redirect_addr  in  BITS  new fetch address, sampled when redirect=1.
REQ-008 SHALL have: halt  in  1  decode saw halt; stop fetching.
REQ-009 SHALL have: stall  in  1  decode cannot accept the presented instruction.
REQ-010 SHALL have: instr_valid  out  1  instr/instr_pc hold a valid instruction.
REQ-011 SHALL have: instr  out  BITS  instruction at queue head; instr_pc  out  BITS  its word address.
REQ-012 SHALL have: fetch_halted  out  1  FSM is in HALTED.

Function
REQ-013 SHALL keep registers: fetch pc, DEPTH-entry circular queue of {instr, pc}, rd/wr pointers, count (0..DEPTH), one in-flight flag with its pc, FSM {RUN, HALTED}.
REQ-014 SHALL drive imem_req=1 in a cycle iff state=RUN, redirect=0, halt=0, and count + in-flight < DEPTH (count before any same-cycle pop).
REQ-015 SHALL drive imem_addr = fetch pc every cycle; on issued request, fetch pc <= fetch pc + 1, wrapping modulo 2^BITS.
REQ-016 SHALL set in-flight=1 with the issued pc at the edge ending a request cycle, else in-flight=0.
REQ-017 SHALL push {imem_rdata, in-flight pc} at the edge ending a cycle with in-flight=1 and redirect=0; fetch-to-instr_valid latency = 2 cycles.
REQ-018 SHALL drive instr_valid = (count != 0), instr/instr_pc from the head entry; zero when count = 0.
REQ-019 SHALL pop the head at an edge when instr_valid=1 and stall=0 and redirect=0.
REQ-020 SHALL, on simultaneous push and pop, leave count unchanged; push into full queue is impossible by REQ-014 (assertion).
REQ-021 SHALL, on redirect=1: clear queue (count=0, pointers equal), discard the in-flight response, set fetch pc <= redirect_addr, issue no request that cycle; redirect has priority over push, pop, halt.
REQ-022 SHALL move RUN -> HALTED on halt=1 (redirect=0); in-flight response still enqueued; queued instructions still drain.
REQ-023 SHALL remain HALTED until reset; redirect in HALTED flushes queue and loads fetch pc but issues no requests.
REQ-024 SHALL hold queue contents and outputs stable while stall=1.
REQ-025 SHALL wrap rd/wr pointers modulo DEPTH.

Reset
REQ-026 SHALL, while rst=1, asynchronously force: fetch pc=RESET_ADDR, count=0, pointers=0, in-flight=0, state=RUN, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_halted=0.
REQ-027 SHALL issue first request at RESET_ADDR the first cycle after rst deasserts.
REQ-028 SHALL, on rst mid-operation, discard all queue and in-flight state.

Verification
REQ-029 Reset release, memory returns pc as data, stall=0 -> imem_req cycle 0 addr 0; instr_valid cycle 2 with instr_pc 0, then 1,2,3 back-to-back.
REQ-030 stall=1 held 10 cycles from cycle 0 -> exactly 4 requests (addr 0..3), count=4, imem_req=0; release stall -> instr_pc 0,1,2,3 in order, fetching resumes at 4.
REQ-031 redirect=1, redirect_addr=0x40 while queue holds 3 entries and one in flight -> next cycle instr_valid=0, in-flight data dropped; next request addr 0x40, instr_pc 0x40 two cycles later.
REQ-032 halt=1 with queue 2 entries, one in flight -> no further imem_req, fetch_halted=1, 3 instructions drain, then instr_valid=0 permanently.
REQ-033 RESET_ADDR=0xFFFFFFFE -> requests 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-034 rst=1 asynchronously mid-burst with full queue -> all outputs zero immediately; restart per REQ-029.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch front end: issues sequential word reads to instruction
//   memory, buffers the returned words with their addresses in a small
//   circular queue and presents the head entry to decode.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   imem_req       instruction memory read request this cycle
//   imem_addr      word address of the request (always the fetch pc)
//   imem_rdata     read data, valid the cycle after the request
//   redirect       branch/jump taken: flush and refetch from redirect_addr
//   redirect_addr  new fetch address, sampled when redirect=1
//   halt           decode saw a halt: stop fetching
//   stall          decode cannot accept the presented instruction
//   instr_valid    instr/instr_pc hold a valid instruction
//   instr          instruction at queue head (zero when empty)
//   instr_pc       word address of the head instruction (zero when empty)
//   fetch_halted   fetch FSM is in HALTED
module fetch_queue #(
  parameter int             BITS       = 32,
  parameter int             DEPTH      = 4,
  parameter logic [BITS-1:0] RESET_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [BITS-1:0] imem_addr,
  input  logic [BITS-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [BITS-1:0] redirect_addr,
  input  logic            halt,
  input  logic            stall,
  output logic            instr_valid,
  output logic [BITS-1:0] instr,
  output logic [BITS-1:0] instr_pc,
  output logic            fetch_halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] fetchPc_q, fetchPc_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            inFlight_q, inFlight_d;
  logic [BITS-1:0] inFlightPc_q, inFlightPc_d;
  logic [BITS-1:0] instrMem_q [DEPTH];
  logic [BITS-1:0] pcMem_q [DEPTH];

  logic [CW:0]     occupancy;
  logic            reqIssue;
  logic            push;
  logic            pop;

  // A request may only go out when the queue is guaranteed room for its
  // response, counting the response already on its way. Reset gates the
  // request so nothing is presented to memory while rst is held.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inFlight_q};
    reqIssue  = !rst && (state_q == RUN) && !redirect && !halt &&
                (occupancy < (CW+1)'(DEPTH));
    push      = inFlight_q && !redirect;
    pop       = (count_q != '0) && !stall && !redirect;
  end

  // Next-state for the fetch pc, queue pointers, occupancy and the single
  // outstanding-request tracker. Redirect wins over everything else: the
  // queue empties and the pending response is simply never enqueued.
  always_comb begin
    fetchPc_d    = fetchPc_q;
    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    count_d      = count_q;
    inFlight_d   = reqIssue;
    inFlightPc_d = fetchPc_q;
    if (redirect) begin
      fetchPc_d = redirect_addr;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
    end else begin
      if (reqIssue) fetchPc_d = fetchPc_q + BITS'(1);
      if (push)     wrPtr_d   = wrPtr_q + PW'(1);
      if (pop)      rdPtr_d   = rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and pointer registers; all cleared asynchronously so a reset
  // mid-burst throws away queued and outstanding work at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q    <= RESET_ADDR;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      count_q      <= '0;
      inFlight_q   <= 1'b0;
      inFlightPc_q <= '0;
    end else begin
      fetchPc_q    <= fetchPc_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
      inFlight_q   <= inFlight_d;
      inFlightPc_q <= inFlightPc_d;
    end
  end

  // Queue storage needs no reset: entries are only visible when count says
  // they are valid, and the output mux below zeroes an empty head.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem_q[wrPtr_q] <= imem_rdata;
      pcMem_q[wrPtr_q]    <= inFlightPc_q;
    end
  end

  // The request throttle should make a push into a full queue unreachable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count_q == CW'(DEPTH))));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state: halt is one-way until reset, and a same-cycle redirect
  // takes precedence so the halt is ignored in that cycle.
  always_comb begin
    state_d = state_q;
    if ((state_q == RUN) && halt && !redirect) state_d = HALTED;
  end

  // FSM and datapath outputs.
  always_comb begin
    fetch_halted = (state_q == HALTED);
    imem_req     = reqIssue;
    imem_addr    = fetchPc_q;
    instr_valid  = (count_q != '0);
    instr        = instr_valid ? instrMem_q[rdPtr_q] : '0;
    instr_pc     = instr_valid ? pcMem_q[rdPtr_q]    : '0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Drives fetch_queue with directed scenarios and a randomized phase, and
//   compares every output every cycle against a queue-based behavioural
//   model. A second instance with a near-wraparound reset address checks
//   that the fetch pc wraps modulo 2^BITS.
module tb_fetch_queue;

  localparam int          BITS      = 32;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] ALT_RESET = 32'hFFFF_FFFE;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        halt;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_halted;

  logic        imemReq2;
  logic [31:0] imemAddr2;
  logic        instrValid2;
  logic [31:0] instr2;
  logic [31:0] instrPc2;
  logic        fetchHalted2;

  fetch_queue #(.BITS(BITS), .DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .halt(halt), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .fetch_halted(fetch_halted)
  );

  fetch_queue #(.BITS(BITS), .DEPTH(DEPTH), .RESET_ADDR(ALT_RESET)) dutWrap (
    .clk(clk), .rst(rst),
    .imem_req(imemReq2), .imem_addr(imemAddr2), .imem_rdata(32'h0),
    .redirect(1'b0), .redirect_addr(32'h0),
    .halt(1'b0), .stall(1'b0),
    .instr_valid(instrValid2), .instr(instr2), .instr_pc(instrPc2),
    .fetch_halted(fetchHalted2)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of {instr, pc}, the address of the single
  // outstanding read, the next address to fetch and a sticky halt flag.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      modelQ[$];
  logic        modelPend;
  logic [31:0] modelPendPc;
  logic [31:0] modelPc;
  logic        modelHalted;
  logic        expReq;

  logic        memValid;
  logic [31:0] memAddr;

  int testCount = 0;
  int failCount = 0;
  int sinceReset = 0;

  // Memory contents: a fixed scramble of the address so data and pc differ.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model for the current cycle.
  task automatic checkOutput();
    logic [31:0] expInstr;
    logic [31:0] expPc;
    expReq = !modelHalted && !redirect && !halt &&
             ((modelQ.size() + int'(modelPend)) < DEPTH);
    expInstr = (modelQ.size() != 0) ? modelQ[0].instr : 32'h0;
    expPc    = (modelQ.size() != 0) ? modelQ[0].pc    : 32'h0;
    checkOne("imem_req",     {31'b0, imem_req},     {31'b0, expReq});
    checkOne("imem_addr",    imem_addr,             modelPc);
    checkOne("instr_valid",  {31'b0, instr_valid},  {31'b0, (modelQ.size() != 0)});
    checkOne("instr",        instr,                 expInstr);
    checkOne("instr_pc",     instr_pc,              expPc);
    checkOne("fetch_halted", {31'b0, fetch_halted}, {31'b0, modelHalted});
    if (sinceReset < 3) begin
      checkOne("wrap_req",  {31'b0, imemReq2}, 32'h1);
      checkOne("wrap_addr", imemAddr2,         ALT_RESET + 32'(sinceReset));
    end
  endtask

  // Advance the model across one clock edge.
  task automatic modelUpdate();
    if (redirect) begin
      modelQ.delete();
      modelPend = 1'b0;
      modelPc   = redirect_addr;
    end else begin
      if ((modelQ.size() != 0) && !stall) void'(modelQ.pop_front());
      if (modelPend) modelQ.push_back({memWord(modelPendPc), modelPendPc});
      if (halt) modelHalted = 1'b1;
      modelPend   = expReq;
      modelPendPc = modelPc;
      if (expReq) modelPc = modelPc + 32'd1;
    end
  endtask

  // One cycle: drive inputs, check at the falling edge, then advance the
  // model and the memory's response just after the rising edge.
  task automatic applyStimulus(input logic s, input logic h, input logic r, input logic [31:0] ra);
    stall         = s;
    halt          = h;
    redirect      = r;
    redirect_addr = ra;
    @(negedge clk);
    checkOutput();
    memValid = imem_req;
    memAddr  = imem_addr;
    @(posedge clk);
    #1;
    modelUpdate();
    imem_rdata = memValid ? memWord(memAddr) : $urandom;
    sinceReset++;
  endtask

  // Assert reset between edges, check outputs collapse at once, release
  // just after the next rising edge so the following cycle is cycle 0.
  task automatic resetDut();
    stall    = 1'b0;
    halt     = 1'b0;
    redirect = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOne("rst_imem_req",     {31'b0, imem_req},     32'h0);
    checkOne("rst_instr_valid",  {31'b0, instr_valid},  32'h0);
    checkOne("rst_instr",        instr,                 32'h0);
    checkOne("rst_instr_pc",     instr_pc,              32'h0);
    checkOne("rst_fetch_halted", {31'b0, fetch_halted}, 32'h0);
    checkOne("rst_imem_addr",    imem_addr,             32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelQ.delete();
    modelPend   = 1'b0;
    modelPendPc = 32'h0;
    modelPc     = 32'h0;
    modelHalted = 1'b0;
    imem_rdata  = 32'h0;
    sinceReset  = 0;
  endtask

  initial begin
    rst           = 1'b0;
    imem_rdata    = 32'h0;
    redirect_addr = 32'h0;
    resetDut();

    // Free-running fetch: request at 0 in cycle 0, valid from cycle 2.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Stall from cycle 0: queue fills with four requests, then drains in order.
    resetDut();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++)  applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect with three queued and one in flight.
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Halt with two queued and one in flight; then a redirect while halted.
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized traffic in several reset-separated bursts.
    for (int b = 0; b < 4; b++) begin
      resetDut();
      for (int i = 0; i < 100; i++) begin
        applyStimulus(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 63) == 0),
                      ($urandom_range(0, 15) == 0),
                      $urandom);
      end
    end

    // Asynchronous reset with a full queue, then a clean restart.
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    resetDut();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
